// File: rtl/marauder_pkg.sv
// Shared types and constants for the marauder ALU control stage.
package marauder_pkg;

  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluSub  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluNor  = 3'b100,
    AluXor  = 3'b101,
    AluXnor = 3'b110,
    AluNand = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRead = 2'b01,
    StExec = 2'b10,
    StWb   = 2'b11
  } ctrl_state_e;

  typedef struct packed {
    alu_op_e    opcode;
    logic [2:0] rd_a;
    logic [2:0] rd_b;
    logic [6:0] wrt_slct;
  } instr_t;

  localparam logic [3:0] BANK_A = 4'b0000;
  localparam logic [3:0] BANK_B = 4'b0001;

endpackage

// File: rtl/marauder_decode.sv
// Splits a latched instruction into its fields and flags whether the write target is a real bank.
module marauder_decode #(
  parameter logic [3:0] BANK_A = marauder_pkg::BANK_A,
  parameter logic [3:0] BANK_B = marauder_pkg::BANK_B
) (
  input  logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [2:0]  rd_a,
  output logic [2:0]  rd_b,
  output logic [6:0]  wrt_slct,
  output logic        wb_valid
);
  import marauder_pkg::*;

  instr_t fields;

  assign fields   = instr_t'(instr);
  assign opcode   = fields.opcode;
  assign rd_a     = fields.rd_a;
  assign rd_b     = fields.rd_b;
  assign wrt_slct = fields.wrt_slct;
  // Any other bank code turns the instruction into a compare-only op.
  assign wb_valid = (fields.wrt_slct[6:3] == BANK_A) || (fields.wrt_slct[6:3] == BANK_B);

endmodule

// File: rtl/marauder_ctrl.sv
// Four-state control stage: fetch operands from banks A/B, run the ALU, write the result back.
module marauder_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter logic [3:0]  BANK_A = marauder_pkg::BANK_A,
  parameter logic [3:0]  BANK_B = marauder_pkg::BANK_B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        rd_slct_a,
  output logic [2:0]        rd_slct_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [6:0]        wrt_slct,
  output logic              wrtnbl,
  output logic [DATA_W-1:0] wb_data,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              busy,
  output logic              done
);
  import marauder_pkg::*;

  ctrl_state_e       state_q, state_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, wb_data_q;
  logic              carry_q, zero_q;
  logic [2:0]        alu_opcode_q;
  logic [6:0]        wrt_slct_q;

  logic [2:0] dec_opcode, dec_rd_a, dec_rd_b;
  logic [6:0] dec_wrt_slct;
  logic       dec_wb_valid;
  logic       accept;

  marauder_decode #(
    .BANK_A(BANK_A),
    .BANK_B(BANK_B)
  ) u_decode (
    .instr    (instr_q),
    .opcode   (dec_opcode),
    .rd_a     (dec_rd_a),
    .rd_b     (dec_rd_b),
    .wrt_slct (dec_wrt_slct),
    .wb_valid (dec_wb_valid)
  );

  assign accept = (state_q == StIdle) && instr_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRead;
      StRead: state_d = StExec;
      StExec: state_d = StWb;
      StWb:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Selects are registered so they only move at state boundaries and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      wb_data_q    <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      wrt_slct_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= instr;
      end
      if (state_q == StRead) begin
        alu_a_q      <= data_a;
        alu_b_q      <= data_b;
        alu_opcode_q <= dec_opcode;
      end
      if (state_q == StExec) begin
        wb_data_q  <= alu_c;
        carry_q    <= alu_carry;
        zero_q     <= alu_zero;
        wrt_slct_q <= dec_wrt_slct;
      end
    end
  end

  // Read selects follow the latched copy, which only changes on accept.
  assign rd_slct_a   = dec_rd_a;
  assign rd_slct_b   = dec_rd_b;
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wrt_slct    = wrt_slct_q;
  assign wb_data     = wb_data_q;
  assign carry_flag  = carry_q;
  assign zero_flag   = zero_q;
  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StWb);
  assign wrtnbl      = (state_q == StWb) && dec_wb_valid;

endmodule

// File: tb/tb_marauder_ctrl.sv
// Directed bench for marauder_ctrl with behavioural register banks and ALU.
module tb_marauder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  rd_slct_a, rd_slct_b, alu_opcode;
  logic [7:0]  data_a, data_b, alu_a, alu_b, alu_c, wb_data;
  logic        alu_carry, alu_zero;
  logic [6:0]  wrt_slct;
  logic        wrtnbl, carry_flag, zero_flag, busy, done;

  logic [7:0] bank_a [8];
  logic [7:0] bank_b [8];
  logic [8:0] alu_res;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  marauder_ctrl #(
    .DATA_W(8),
    .BANK_A(4'b0000),
    .BANK_B(4'b0001)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rd_slct_a   (rd_slct_a),
    .rd_slct_b   (rd_slct_b),
    .data_a      (data_a),
    .data_b      (data_b),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .wrt_slct    (wrt_slct),
    .wrtnbl      (wrtnbl),
    .wb_data     (wb_data),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .busy        (busy),
    .done        (done)
  );

  assign data_a = bank_a[rd_slct_a];
  assign data_b = bank_b[rd_slct_b];

  always_comb begin
    alu_res = 9'd0;
    case (alu_opcode)
      3'd0: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_res = {1'b0, alu_a & alu_b};
      3'd3: alu_res = {1'b0, alu_a | alu_b};
      3'd4: alu_res = {1'b0, ~(alu_a | alu_b)};
      3'd5: alu_res = {1'b0, alu_a ^ alu_b};
      3'd6: alu_res = {1'b0, ~(alu_a ^ alu_b)};
      default: alu_res = {1'b0, ~(alu_a & alu_b)};
    endcase
  end
  assign alu_c     = alu_res[7:0];
  assign alu_carry = alu_res[8];
  assign alu_zero  = (alu_res[7:0] == 8'd0);

  typedef struct {
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [6:0] ws;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] wb;
    logic       c;
    logic       z;
    logic       we;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; the bank model absorbs a write pulse seen there.
  task automatic cyc();
    @(negedge clk);
    if (wrtnbl) begin
      if (wrt_slct[6:3] == 4'b0000) bank_a[wrt_slct[2:0]] = wb_data;
      else if (wrt_slct[6:3] == 4'b0001) bank_b[wrt_slct[2:0]] = wb_data;
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [6:0] ws);
    return {op, ra, rb, ws};
  endfunction

  task automatic issue(input string id, input logic [15:0] ins, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] ewb, input logic ec,
                       input logic ez, input logic ewe);
    chk({id, " ready"}, instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    instr = 16'hffff;
    chk({id, " read busy/ready"}, {busy, instr_ready}, 2'b10);
    chk({id, " rd_slct"}, {rd_slct_a, rd_slct_b}, {ins[12:10], ins[9:7]});
    cyc();
    chk({id, " operands"}, {alu_a, alu_b}, {ea, eb});
    chk({id, " opcode"}, alu_opcode, ins[15:13]);
    chk({id, " exec done/wr"}, {done, wrtnbl}, 2'b00);
    cyc();
    chk({id, " wb_data"}, wb_data, ewb);
    chk({id, " flags"}, {carry_flag, zero_flag}, {ec, ez});
    chk({id, " wb done/wrtnbl"}, {done, wrtnbl}, {1'b1, ewe});
    chk({id, " wrt_slct"}, wrt_slct, ins[6:0]);
    cyc();
    chk({id, " idle done/wr/ready"}, {done, wrtnbl, instr_ready}, 3'b001);
    chk({id, " flags hold"}, {carry_flag, zero_flag}, {ec, ez});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      bank_a[i] = 8'd0;
      bank_b[i] = 8'd0;
    end
    //              op    ra    rb    ws           va     vb     wb     c     z     we
    vecs[0] = '{3'd0, 3'd2, 3'd3, 7'b0000_100, 8'd6,   8'd21,  8'd27,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{3'd0, 3'd1, 3'd5, 7'b0001_000, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b1};
    vecs[2] = '{3'd1, 3'd3, 3'd2, 7'b0000_110, 8'd5,   8'd5,   8'd0,   1'b0, 1'b1, 1'b1};
    vecs[3] = '{3'd3, 3'd5, 3'd6, 7'b0100_011, 8'h0f,  8'hf0,  8'hff,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'd1, 3'd4, 3'd4, 7'b0001_010, 8'd3,   8'd5,   8'hfe,  1'b1, 1'b0, 1'b1};
    vecs[5] = '{3'd2, 3'd0, 3'd1, 7'b0001_111, 8'd6,   8'd21,  8'd4,   1'b0, 1'b0, 1'b1};
    vecs[6] = '{3'd5, 3'd6, 3'd7, 7'b0000_001, 8'haa,  8'haa,  8'h00,  1'b0, 1'b1, 1'b1};
    vecs[7] = '{3'd4, 3'd1, 3'd1, 7'b1111_000, 8'h0f,  8'h30,  8'hc0,  1'b0, 1'b0, 1'b0};
    vecs[8] = '{3'd7, 3'd7, 3'd0, 7'b0001_101, 8'hff,  8'h0f,  8'hf0,  1'b0, 1'b0, 1'b1};
    vecs[9] = '{3'd6, 3'd2, 3'd2, 7'b0000_000, 8'h0f,  8'h0f,  8'hff,  1'b0, 1'b0, 1'b1};

    #2 rst_n = 1'b0;
    cyc();
    cyc();
    chk("reset ready", instr_ready, 1);
    chk("reset ctrl outs", {busy, done, wrtnbl, carry_flag, zero_flag, rd_slct_a, rd_slct_b,
                            alu_opcode, wrt_slct}, 0);
    chk("reset data outs", {alu_a, alu_b, wb_data}, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle stays idle", {instr_ready, busy}, 2'b10);

    for (int i = 0; i < NV; i++) begin
      bank_a[vecs[i].ra] = vecs[i].va;
      bank_b[vecs[i].rb] = vecs[i].vb;
      issue($sformatf("v%0d", i), mk(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].ws),
            vecs[i].va, vecs[i].vb, vecs[i].wb, vecs[i].c, vecs[i].z, vecs[i].we);
      if (vecs[i].we) begin
        if (vecs[i].ws[6:3] == 4'b0000) chk($sformatf("v%0d bank", i), bank_a[vecs[i].ws[2:0]],
                                            vecs[i].wb);
        else chk($sformatf("v%0d bank", i), bank_b[vecs[i].ws[2:0]], vecs[i].wb);
      end
    end

    // Read-after-write: result written to A[4] is the operand of the very next instruction.
    bank_a[2] = 8'd6;
    bank_b[3] = 8'd21;
    bank_a[4] = 8'd0;
    issue("raw1", mk(3'd0, 3'd2, 3'd3, 7'b0000_100), 8'd6, 8'd21, 8'd27, 1'b0, 1'b0, 1'b1);
    chk("raw A4", bank_a[4], 8'd27);
    issue("raw2", mk(3'd0, 3'd4, 3'd3, 7'b0000_101), 8'd27, 8'd21, 8'd48, 1'b0, 1'b0, 1'b1);
    chk("raw A5", bank_a[5], 8'd48);

    // Back-to-back with valid held high; instr changes while busy are ignored.
    bank_a[2] = 8'd6;
    bank_b[3] = 8'd21;
    instr = mk(3'd0, 3'd2, 3'd3, 7'b0000_101);
    instr_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("tput ready k%0d", k), instr_ready, (k % 4 == 0) ? 1 : 0);
      if (k == 1) instr = 16'hffff;
      if (k == 3) chk("tput wb1", {done, wb_data, wrt_slct}, {1'b1, 8'd27, 7'b0000_101});
      if (k == 4) instr = mk(3'd1, 3'd2, 3'd3, 7'b0001_110);
      if (k == 5) instr = 16'h0000;
      if (k == 7) chk("tput wb2", {done, wb_data, carry_flag, wrt_slct},
                      {1'b1, 8'hf1, 1'b1, 7'b0001_110});
      if (k == 8) instr_valid = 1'b0;
      cyc();
    end
    chk("tput drained", {instr_ready, busy}, 2'b10);
    chk("tput B6", bank_b[6], 8'hf1);

    // Reset during EXEC: pending write dropped, flags cleared.
    bank_a[1] = 8'd200;
    bank_b[5] = 8'd100;
    issue("pre", mk(3'd0, 3'd1, 3'd5, 7'b0000_000), 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b1);
    bank_a[7] = 8'h55;
    instr = mk(3'd0, 3'd1, 3'd5, 7'b0000_111);
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    cyc();
    chk("rst exec busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst async ready/busy", {instr_ready, busy, done, wrtnbl}, 4'b1000);
    chk("rst async flags", {carry_flag, zero_flag, wb_data}, 0);
    cyc();
    chk("rst held", {instr_ready, busy, done, wrtnbl}, 4'b1000);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("rst no write", bank_a[7], 8'h55);
    chk("rst after idle", {instr_ready, wrtnbl, carry_flag, zero_flag}, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
